stopwatch_ctrl_fsm: RTL

//   Control FSM directly upstream of the stopwatch counter. Debounces the two raw push-buttons
//   (start/stop, reset) and drives the counter's timer_run_en and timer_reset_cmd inputs.

---
 rtl/stopwatch_ctrl_fsm_pkg.sv | 20 ++
 rtl/stopwatch_ctrl_fsm_debouncer.sv | 43 ++++
 rtl/stopwatch_ctrl_fsm.sv | 136 +++++++++++++
 3 files changed

// File: rtl/stopwatch_ctrl_fsm_pkg.sv
// Shared state codes and build-time defaults for the stopwatch control FSM.
// Holds the debounce lengths for simulation and board builds.
package stopwatch_ctrl_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_ALARM = 2'd3
    } state_t;

    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 2_000_000;
    localparam int ALARM_TOGGLES_DEFAULT = 10;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/stopwatch_ctrl_fsm_debouncer.sv
// button_debouncer: 2-FF synchroniser plus stable-count debounce for one raw button.
// Emits a one-cycle pulse on the debounced rising edge only.
module button_debouncer
    import stopwatch_ctrl_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;

    // Count consecutive cycles where the synchronised input disagrees with the level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q    <= 2'b00;
            cnt_q     <= '0;
            btn_level <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw};
            btn_pulse <= 1'b0;
            if (sync_q[1] == btn_level) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                cnt_q     <= '0;
                btn_level <= sync_q[1];
                btn_pulse <= sync_q[1];
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl_fsm.sv
// Stopwatch control FSM: debounced buttons drive counter run/clear and the alarm LED.
// Define ALARM_TIMEOUT_EN to auto-leave ALARM after ALARM_TOGGLES LED toggles.
//
//   state    | meaning
//   ST_IDLE  | counter stopped, waiting for start
//   ST_RUN   | counter running
//   ST_PAUSE | counter held, value kept
//   ST_ALARM | max time reached, LED blinking
module stopwatch_ctrl_fsm
    import stopwatch_ctrl_fsm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_BOARD,
    parameter int ALARM_TOGGLES   = ALARM_TOGGLES_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start_stop,
    input  logic       btn_reset,
    input  logic       max_time_reached,
    input  logic       blink_clk_enable,
    output logic       timer_run_en,
    output logic       timer_reset_cmd,
    output logic       alarm_led,
    output logic [1:0] state_out
);

    state_t state_q, state_nxt;
    logic   clear_nxt, led_nxt;
    logic   start_pulse, reset_pulse;
    logic   start_level_unused, reset_level_unused;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_start_stop),
        .btn_level (start_level_unused),
        .btn_pulse (start_pulse)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_reset (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_reset),
        .btn_level (reset_level_unused),
        .btn_pulse (reset_pulse)
    );

`ifdef ALARM_TIMEOUT_EN
    localparam int TOG_W = cnt_width(ALARM_TOGGLES);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(ALARM_TOGGLES - 1);

    logic [TOG_W-1:0] tog_q, tog_nxt;
    logic             tog_last;

    assign tog_last = (tog_q == TOG_LAST);
`endif

    always_comb begin
        state_nxt = state_q;
        clear_nxt = 1'b0;
        led_nxt   = alarm_led;
        unique case (state_q)
            ST_IDLE: begin
                if (reset_pulse)      clear_nxt = 1'b1;
                else if (start_pulse) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (max_time_reached) begin
                    state_nxt = ST_ALARM;
                end else if (reset_pulse) begin
                    state_nxt = ST_IDLE;
                    clear_nxt = 1'b1;
                end else if (start_pulse) begin
                    state_nxt = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (reset_pulse) begin
                    state_nxt = ST_IDLE;
                    clear_nxt = 1'b1;
                end else if (start_pulse) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_ALARM: begin
                if (reset_pulse) begin
                    state_nxt = ST_IDLE;
                    clear_nxt = 1'b1;
                end else if (blink_clk_enable) begin
                    led_nxt = ~alarm_led;
`ifdef ALARM_TIMEOUT_EN
                    if (tog_last) begin
                        state_nxt = ST_IDLE;
                        clear_nxt = 1'b1;
                    end
`endif
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // LED is lit on ALARM entry and dark everywhere outside ALARM.
        if (state_nxt != ST_ALARM)     led_nxt = 1'b0;
        else if (state_q != ST_ALARM)  led_nxt = 1'b1;
    end

`ifdef ALARM_TIMEOUT_EN
    always_comb begin
        tog_nxt = '0;
        if (state_nxt == ST_ALARM && state_q == ST_ALARM) begin
            tog_nxt = blink_clk_enable ? tog_q + TOG_W'(1) : tog_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) tog_q <= '0;
        else       tog_q <= tog_nxt;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            timer_run_en    <= 1'b0;
            timer_reset_cmd <= 1'b0;
            alarm_led       <= 1'b0;
        end else begin
            state_q         <= state_nxt;
            timer_run_en    <= (state_nxt == ST_RUN);
            timer_reset_cmd <= clear_nxt;
            alarm_led       <= led_nxt;
        end
    end

    assign state_out = state_q;

endmodule
